code_lock: RTL
==============

CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of BCD digits in the password (range 2..8).
REQ-002 SHALL have parameter MAX_TRIES, default 3, consecutive failed OPEN attempts that trigger lockout (range 1..15).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 1024, lockout duration in CLK cycles (at least 2).
REQ-004 SHALL have parameter RELOCK_CYCLES, default 4096, idle-open timeout in CLK cycles; used only under AUTO_RELOCK_EN.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port KEY_VALID, input, 1 bit: one-cycle strobe marking a keypad digit.
REQ-008 SHALL have port KEY_CODE, input, 4 bits: BCD digit, sampled when KEY_VALID=1.
REQ-009 SHALL have ports OPEN, CLOSE and SET, each input, 1 bit: one-cycle command strobes.
REQ-010 SHALL have port LOCK, output, 1 bit: 1 = unlocked (open), 0 = locked.
REQ-011 SHALL have port ALARM, output, 1 bit: 1 while in lockout.
REQ-012 SHALL have port DIGIT_CNT, output, 4 bits: digits currently held in the entry buffer.
REQ-013 SHALL have port FAIL_CNT, output, 4 bits: consecutive failed attempts.

Function
REQ-014 SHALL implement the states CLOSED, OPENED and LOCKOUT, and all outputs SHALL be registered.
REQ-015 SHALL ignore KEY_VALID when KEY_CODE > 9.
REQ-016 A valid key SHALL shift into an NDIGITS*4-bit entry buffer, newest digit in the least-significant nibble, and increment DIGIT_CNT.
REQ-017 DIGIT_CNT SHALL saturate at NDIGITS, and further digits SHALL be ignored until the buffer is cleared.
REQ-018 When several strobes arrive in one cycle, priority SHALL be CLOSE > SET > OPEN > KEY_VALID, and only the highest-priority strobe SHALL act.
REQ-019 In CLOSED, OPEN with DIGIT_CNT==NDIGITS and buffer==password SHALL set LOCK=1, clear FAIL_CNT, clear the buffer and go to OPENED, with LOCK high in the cycle after the strobe edge.
REQ-020 In CLOSED, OPEN with a mismatch or with DIGIT_CNT<NDIGITS SHALL increment FAIL_CNT and clear the buffer.
REQ-021 When FAIL_CNT reaches MAX_TRIES, the FSM SHALL go to LOCKOUT with ALARM=1 in the next cycle.
REQ-022 In CLOSED, CLOSE SHALL clear the buffer and leave FAIL_CNT unchanged, and SET SHALL be ignored.
REQ-023 In OPENED, digits SHALL accumulate as in CLOSED.
REQ-024 In OPENED, SET with DIGIT_CNT==NDIGITS SHALL load the password from the buffer, clear the buffer and stay OPENED; SET with fewer digits SHALL be ignored.
REQ-025 In OPENED, CLOSE SHALL set LOCK=0, clear the buffer and go to CLOSED; OPEN SHALL be ignored.
REQ-026 In LOCKOUT, all key and command strobes SHALL be ignored, including CLOSE.
REQ-027 In LOCKOUT, a down-counter SHALL run for LOCKOUT_CYCLES cycles, then clear ALARM and FAIL_CNT, clear the buffer and go to CLOSED.
REQ-028 LOCK SHALL never be 1 outside OPENED.

Reset
REQ-029 RESET=1 SHALL asynchronously force state CLOSED, LOCK=0, ALARM=0, DIGIT_CNT=0, FAIL_CNT=0, entry buffer=0, password=all zeros, and all counters=0.
REQ-030 RESET asserted mid-lockout or mid-entry SHALL abort the operation with no residual state.
REQ-031 After RESET is released, the FSM SHALL accept strobes from the first rising CLK edge.

Configuration
REQ-032 SHALL provide the macro CODE_LOCK_AUTO_RELOCK_EN.
REQ-033 With CODE_LOCK_AUTO_RELOCK_EN defined, OPENED SHALL return to CLOSED (LOCK=0, buffer cleared) after RELOCK_CYCLES consecutive cycles with no KEY_VALID, OPEN, SET or CLOSE; any such strobe SHALL reload the timer.
REQ-034 Without CODE_LOCK_AUTO_RELOCK_EN, OPENED SHALL persist until CLOSE or RESET, and no relock timer logic SHALL be present.

Verification (NDIGITS=4, MAX_TRIES=3, LOCKOUT_CYCLES=8, RELOCK_CYCLES=16)
REQ-035 Reset, then keys 0,0,0,0, then OPEN -> LOCK=1 one cycle after OPEN, FAIL_CNT=0.
REQ-036 While open: keys 1,2,3,4, SET, CLOSE; then keys 1,2,3,4, OPEN -> LOCK=1; and keys 0,0,0,0, OPEN from CLOSED -> FAIL_CNT=1, LOCK=0.
REQ-037 Three wrong 4-digit OPENs -> ALARM=1 for exactly 8 cycles, during which keys, OPEN and CLOSE have no effect; afterwards FAIL_CNT=0, ALARM=0, state CLOSED.
REQ-038 Keys 5,6,7,8,9 then OPEN with password 5678 -> fifth digit ignored, DIGIT_CNT=4, LOCK=1; KEY_CODE=12 with KEY_VALID -> DIGIT_CNT unchanged.
REQ-039 CLOSE and OPEN in the same cycle while the correct code is entered -> CLOSE wins, buffer cleared, LOCK=0; RESET pulsed during lockout -> ALARM=0, password=0000 immediately.
REQ-040 With CODE_LOCK_AUTO_RELOCK_EN defined, open the lock and stay idle 16 cycles -> LOCK=0; a key at cycle 10 -> relock at cycle 26.

Source files
------------

// File: rtl/code_lock.sv
// Keypad code lock: CLOSED / OPENED / LOCKOUT FSM with a BCD entry buffer.
// Define CODE_LOCK_AUTO_RELOCK_EN to add the idle-open relock timer.
module code_lock #(
    parameter int NDIGITS        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int RELOCK_CYCLES  = 4096
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_CODE,
    input  logic       OPEN,
    input  logic       CLOSE,
    input  logic       SET,
    output logic       LOCK,
    output logic       ALARM,
    output logic [3:0] DIGIT_CNT,
    output logic [3:0] FAIL_CNT
);

    localparam int BW = NDIGITS * 4;
    localparam int LW = $clog2(LOCKOUT_CYCLES);

    if (NDIGITS < 2 || NDIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
        LOCKOUT_CYCLES < 2 || RELOCK_CYCLES < 2) begin : g_param_err
        $error("code_lock: parameter out of range");
    end

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENED  = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [BW-1:0]   pwd_q, pwd_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      fail_q, fail_d;
    logic            lock_q, lock_d;
    logic            alarm_q, alarm_d;
    logic [LW-1:0]   lk_q, lk_d;

    logic            key_ok;
    logic            full;
    logic            match;
    logic [3:0]      fail_inc;

    assign key_ok   = KEY_VALID && (KEY_CODE <= 4'd9) &&
                      (cnt_q < 4'(NDIGITS));
    assign full     = (cnt_q == 4'(NDIGITS));
    assign match    = full && (buf_q == pwd_q);
    assign fail_inc = fail_q + 4'd1;

`ifdef CODE_LOCK_AUTO_RELOCK_EN
    localparam int RW = $clog2(RELOCK_CYCLES);
    logic [RW-1:0] rl_q, rl_d;
    logic          any_strobe;

    assign any_strobe = KEY_VALID | OPEN | SET | CLOSE;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pwd_d   = pwd_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        alarm_d = alarm_q;
        lk_d    = lk_q;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
        rl_d    = rl_q;
`endif
        unique case (state_q)
            CLOSED: begin
                if (CLOSE) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (SET) begin
                    buf_d = buf_q;
                end else if (OPEN) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (match) begin
                        state_d = OPENED;
                        lock_d  = 1'b1;
                        fail_d  = '0;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
                        rl_d    = RW'(RELOCK_CYCLES - 1);
`endif
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == 4'(MAX_TRIES)) begin
                            state_d = LOCKOUT;
                            alarm_d = 1'b1;
                            lk_d    = LW'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end else if (key_ok) begin
                    buf_d = {buf_q[BW-5:0], KEY_CODE};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            OPENED: begin
`ifdef CODE_LOCK_AUTO_RELOCK_EN
                // Idle timeout first; any strobe below still acts normally.
                if (any_strobe) begin
                    rl_d = RW'(RELOCK_CYCLES - 1);
                end else if (rl_q == '0) begin
                    state_d = CLOSED;
                    lock_d  = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    rl_d = rl_q - RW'(1);
                end
`endif
                if (CLOSE) begin
                    state_d = CLOSED;
                    lock_d  = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (SET) begin
                    if (full) begin
                        pwd_d = buf_q;
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (OPEN) begin
                    buf_d = buf_q;
                end else if (key_ok) begin
                    buf_d = {buf_q[BW-5:0], KEY_CODE};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            LOCKOUT: begin
                if (lk_q == '0) begin
                    state_d = CLOSED;
                    alarm_d = 1'b0;
                    fail_d  = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    lk_d = lk_q - LW'(1);
                end
            end
            default: begin
                state_d = CLOSED;
                lock_d  = 1'b0;
                alarm_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= CLOSED;
            buf_q   <= '0;
            pwd_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            lock_q  <= 1'b0;
            alarm_q <= 1'b0;
            lk_q    <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pwd_q   <= pwd_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
            alarm_q <= alarm_d;
            lk_q    <= lk_d;
        end
    end

`ifdef CODE_LOCK_AUTO_RELOCK_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rl_q <= '0;
        end else begin
            rl_q <= rl_d;
        end
    end
`endif

    assign LOCK      = lock_q;
    assign ALARM     = alarm_q;
    assign DIGIT_CNT = cnt_q;
    assign FAIL_CNT  = fail_q;

endmodule
